memory_cycle: RTL

Memory-access (MA) stage of the SimpleRISC pipeline. It takes the instruction held in the EX/MA latch and performs `ld`/`st` against an internal word-addressed data memory with configurable access latency. It stalls the upstream stages while an access is in flight, then loads the MA/RW pipeline latch that feeds the writeback stage. Non-memory instructions pass through in one cycle.

---
 rtl/memory_cycle.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/memory_cycle.sv
// Memory-access stage of the SimpleRISC pipeline: ld/st against an internal
// word-addressed data memory with a fixed access latency, then loads the MA/RW latch.
module memory_cycle #(
  parameter int MEM_DEPTH = 1024,
  parameter int MEM_LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_MA,
  input  logic [31:0] pc_MA,
  input  logic [31:0] alu_result_MA,
  input  logic [31:0] instruction_MA,
  input  logic [31:0] op2_MA,
  input  logic [3:0]  RS1_MA,
  input  logic [3:0]  RS2_MA,
  input  logic [3:0]  RD_MA,
  input  logic [3:0]  ra_MA,
  input  logic        isLd_MA,
  input  logic        isSt_MA,
  input  logic        isWb_MA,
  input  logic        isCall_MA,
  input  logic        isRet_MA,
  input  logic        isSet_MA,
  input  logic        isReset_MA,
  input  logic [4:0]  alusignals_MA,
  output logic        stall_MA,
  output logic [31:0] pc_RW,
  output logic [31:0] alu_result_RW,
  output logic [31:0] instruction_RW,
  output logic [31:0] ldresult_RW,
  output logic [3:0]  RS1_RW,
  output logic [3:0]  RS2_RW,
  output logic [3:0]  RD_RW,
  output logic [3:0]  ra_RW,
  output logic        isLd_RW,
  output logic        isSt_RW,
  output logic        isWb_RW,
  output logic        isCall_RW,
  output logic        isRet_RW,
  output logic        isSet_RW,
  output logic        isReset_RW,
  output logic [4:0]  alusignals_RW,
  output logic        valid_RW
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] ins;
    logic [31:0] ldres;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic [3:0]  ra;
    logic        ld;
    logic        st;
    logic        wb;
    logic        call;
    logic        ret;
    logic        set;
    logic        rs;
    logic [4:0]  alus;
  } rw_t;

  logic [31:0]   mem [MEM_DEPTH];
  logic [AW-1:0] idx;
  logic [31:0]   rd_data;
  logic          memop, done;
  logic [CW-1:0] wcnt_q, wcnt_d;
  rw_t           rw_q, rw_d;

  assign idx      = alu_result_MA[AW+1:2];
  assign rd_data  = mem[idx];
  assign memop    = valid_MA & (isLd_MA | isSt_MA);
  assign done     = ~memop | (wcnt_q == LAST);
  assign stall_MA = memop & ~done;

  always_comb begin
    wcnt_d = '0;
    if (stall_MA) wcnt_d = wcnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) wcnt_q <= '0;
    else      wcnt_q <= wcnt_d;
  end

  // No reset on the array; a store aborted by reset never reaches it.
  always_ff @(posedge clk) begin
    if (rst && memop && done && isSt_MA) mem[idx] <= op2_MA;
  end

  always_comb begin
    rw_d = '0;
    if (done) begin
      rw_d.valid = valid_MA;
      rw_d.pc    = pc_MA;
      rw_d.alu   = alu_result_MA;
      rw_d.ins   = instruction_MA;
      rw_d.rs1   = RS1_MA;
      rw_d.rs2   = RS2_MA;
      rw_d.rd    = RD_MA;
      rw_d.ra    = ra_MA;
      rw_d.alus  = alusignals_MA;
      if (valid_MA) begin
        rw_d.ld   = isLd_MA;
        rw_d.st   = isSt_MA;
        rw_d.wb   = isWb_MA;
        rw_d.call = isCall_MA;
        rw_d.ret  = isRet_MA;
        rw_d.set  = isSet_MA;
        rw_d.rs   = isReset_MA;
      end
      // ld+st together behaves as a store, so no load data.
      if (memop && isLd_MA && !isSt_MA) rw_d.ldres = rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) rw_q <= '0;
    else      rw_q <= rw_d;
  end

  assign valid_RW       = rw_q.valid;
  assign pc_RW          = rw_q.pc;
  assign alu_result_RW  = rw_q.alu;
  assign instruction_RW = rw_q.ins;
  assign ldresult_RW    = rw_q.ldres;
  assign RS1_RW         = rw_q.rs1;
  assign RS2_RW         = rw_q.rs2;
  assign RD_RW          = rw_q.rd;
  assign ra_RW          = rw_q.ra;
  assign isLd_RW        = rw_q.ld;
  assign isSt_RW        = rw_q.st;
  assign isWb_RW        = rw_q.wb;
  assign isCall_RW      = rw_q.call;
  assign isRet_RW       = rw_q.ret;
  assign isSet_RW       = rw_q.set;
  assign isReset_RW     = rw_q.rs;
  assign alusignals_RW  = rw_q.alus;

endmodule
